// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction-fetch request stage
//
// Issues instruction fetch addresses on the AXI4-Lite AR channel and keeps a
// FIFO of issued PCs so that each returning R beat is presented with its PC,
// its return address (PC+4) and a stale flag. Redirects flip an epoch bit.
// Entries tagged with an older epoch are flagged so decode discards the beat.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   o_im_arvalid/i_im_arready  AR handshake
//   o_im_araddr, o_im_arprot   fetch address, fixed protection bits
//   i_im_rvalid/i_im_rready    R handshake, observed only
//   i_im_rresp                 R response, checked for errors
//   i_redir_valid/i_redir_addr redirect request from execute
//   o_pc_valid/o_pc_addr       head of the issued-PC FIFO
//   o_pc_ret_addr              o_pc_addr + 4
//   o_pc_stale                 head entry predates the latest redirect
//   o_fault/o_fault_addr       sticky fetch fault and its address
module fetch_unit #(
    parameter int unsigned          XLEN            = 32,
    parameter logic [XLEN-1:0]      RESET_ADDR      = '0,
    parameter int unsigned          MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            o_im_arvalid,
    input  logic            i_im_arready,
    output logic [XLEN-1:0] o_im_araddr,
    output logic [2:0]      o_im_arprot,
    input  logic            i_im_rvalid,
    input  logic            i_im_rready,
    input  logic [1:0]      i_im_rresp,
    input  logic            i_redir_valid,
    input  logic [XLEN-1:0] i_redir_addr,
    output logic            o_pc_valid,
    output logic [XLEN-1:0] o_pc_addr,
    output logic [XLEN-1:0] o_pc_ret_addr,
    output logic            o_pc_stale,
    output logic            o_fault,
    output logic [XLEN-1:0] o_fault_addr
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [XLEN-1:0]  INSN_BYTES = XLEN'(4);

    // Request register: araddr/epoch hold steady while arvalid waits for arready.
    logic            arvalid_q, arvalid_d;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            ar_epoch_q, ar_epoch_d;

    // pc_q is the address the next newly loaded request will carry.
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;

    logic [XLEN-1:0] fifo_addr_q  [MAX_OUTSTANDING];
    logic            fifo_epoch_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    logic            arh, rh, pop;
    logic            redir_ok, redir_bad;
    logic            hold, load;
    logic [XLEN-1:0] pc_x;
    logic [XLEN-1:0] head_addr;
    logic            head_epoch;
    logic            head_valid, head_stale;
    logic            rsp_fault;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign arh       = arvalid_q & i_im_arready;
    assign rh        = i_im_rvalid & i_im_rready;
    // A beat with nothing outstanding has no PC to pair with; drop it.
    assign pop       = rh & (cnt_q != '0);
    assign redir_ok  = i_redir_valid & (i_redir_addr[1:0] == 2'b00);
    assign redir_bad = i_redir_valid & (i_redir_addr[1:0] != 2'b00);

    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_epoch = fifo_epoch_q[rd_ptr_q];
    assign head_valid = (cnt_q != '0);
    assign head_stale = head_valid & (head_epoch != epoch_q);
    assign rsp_fault  = pop & (i_im_rresp != 2'b00) & ~head_stale;

    always_comb begin
        cnt_d        = cnt_q;
        epoch_d      = epoch_q;
        pc_x         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        araddr_d     = araddr_q;
        ar_epoch_d   = ar_epoch_q;

        if (arh && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!arh && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (redir_ok) begin
            epoch_d = ~epoch_q;
            pc_x    = i_redir_addr;
        end

        // First fault wins; its address is kept until reset.
        if (!fault_q) begin
            if (redir_bad) begin
                fault_d      = 1'b1;
                fault_addr_d = i_redir_addr;
            end else if (rsp_fault) begin
                fault_d      = 1'b1;
                fault_addr_d = head_addr;
            end
        end

        // A pending request is never withdrawn; a new one loads only when it
        // cannot overflow the outstanding budget (counting this cycle's beats).
        hold      = arvalid_q & ~i_im_arready;
        load      = ~hold & (cnt_d < MAX_CNT) & ~fault_d;
        arvalid_d = hold | load;
        pc_d      = pc_x;
        if (load) begin
            araddr_d   = pc_x;
            ar_epoch_d = epoch_d;
            pc_d       = pc_x + INSN_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= RESET_ADDR;
            ar_epoch_q   <= 1'b0;
            pc_q         <= RESET_ADDR;
            epoch_q      <= 1'b0;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            ar_epoch_q   <= ar_epoch_d;
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            if (arh) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (rstn && arh) begin
            fifo_addr_q[wr_ptr_q]  <= araddr_q;
            fifo_epoch_q[wr_ptr_q] <= ar_epoch_q;
        end
    end

    property p_no_orphan_beat;
        @(posedge clk) disable iff (!rstn) !(rh && (cnt_q == '0));
    endproperty
    a_no_orphan_beat: assert property (p_no_orphan_beat);

    assign o_im_arvalid  = arvalid_q;
    assign o_im_araddr   = araddr_q;
    assign o_im_arprot   = 3'b100;
    assign o_pc_valid    = head_valid;
    assign o_pc_addr     = head_addr;
    assign o_pc_ret_addr = head_addr + INSN_BYTES;
    assign o_pc_stale    = head_stale;
    assign o_fault       = fault_q;
    assign o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic [31:0] pc_ret_addr;
    logic        pc_stale;
    logic        fault;
    logic [31:0] fault_addr;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .XLEN            (32),
        .RESET_ADDR      (32'h0000_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .o_im_arvalid  (arvalid),
        .i_im_arready  (arready),
        .o_im_araddr   (araddr),
        .o_im_arprot   (arprot),
        .i_im_rvalid   (rvalid),
        .i_im_rready   (rready),
        .i_im_rresp    (rresp),
        .i_redir_valid (redir_valid),
        .i_redir_addr  (redir_addr),
        .o_pc_valid    (pc_valid),
        .o_pc_addr     (pc_addr),
        .o_pc_ret_addr (pc_ret_addr),
        .o_pc_stale    (pc_stale),
        .o_fault       (fault),
        .o_fault_addr  (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ar);
        rstn        = 1'b0;
        arready     = ar;
        rvalid      = 1'b0;
        rready      = 1'b1;
        rresp       = 2'b00;
        redir_valid = 1'b0;
        redir_addr  = '0;
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    initial begin
        rstn        = 1'b0;
        arready     = 1'b1;
        rvalid      = 1'b0;
        rready      = 1'b1;
        rresp       = 2'b00;
        redir_valid = 1'b0;
        redir_addr  = '0;

        // Reset state and streaming fetch with 1-cycle beat return
        cyc();
        cyc();
        check_eq("rst_arvalid", 32'(arvalid), 32'd0);
        check_eq("rst_araddr", araddr, 32'h0);
        check_eq("rst_pc_valid", 32'(pc_valid), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_fault_addr", fault_addr, 32'h0);
        check_eq("arprot", 32'(arprot), 32'd4);
        rstn = 1'b1;
        cyc();
        check_eq("first_arvalid", 32'(arvalid), 32'd1);
        check_eq("first_araddr", araddr, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            rvalid = 1'b1;
            check_eq($sformatf("stream_araddr%0d", i), araddr, 32'(4 * i));
            check_eq($sformatf("stream_pc%0d", i), pc_addr, 32'(4 * (i - 1)));
            check_eq($sformatf("stream_ret%0d", i), pc_ret_addr, 32'(4 * i));
            check_eq($sformatf("stream_stale%0d", i), 32'(pc_stale), 32'd0);
        end

        // Error response on non-stale beat for 0xC: head is C here
        rresp = 2'b10;
        cyc();
        rresp = 2'b00;
        check_eq("rsp_fault", 32'(fault), 32'd1);
        check_eq("rsp_fault_addr", fault_addr, 32'hC);
        check_eq("rsp_fault_no_issue", 32'(arvalid), 32'd0);
        cyc();
        rvalid = 1'b0;
        cyc();
        cyc();
        check_eq("fault_still_no_issue", 32'(arvalid), 32'd0);
        check_eq("fault_drained", 32'(pc_valid), 32'd0);
        do_reset(1'b1);
        check_eq("fault_cleared", 32'(fault), 32'd0);
        check_eq("restart_arvalid", 32'(arvalid), 32'd1);
        check_eq("restart_araddr", araddr, 32'h0);

        // Back-pressure and outstanding limit
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq($sformatf("hold_arvalid%0d", i), 32'(arvalid), 32'd1);
            check_eq($sformatf("hold_araddr%0d", i), araddr, 32'h0);
        end
        arready = 1'b1;
        cyc();
        check_eq("lim_araddr4", araddr, 32'h4);
        check_eq("lim_arvalid_1", 32'(arvalid), 32'd1);
        cyc();
        check_eq("lim_arvalid_full", 32'(arvalid), 32'd0);
        cyc();
        check_eq("lim_arvalid_full2", 32'(arvalid), 32'd0);
        check_eq("lim_head", pc_addr, 32'h0);
        rvalid = 1'b1;
        cyc();
        rvalid = 1'b0;
        check_eq("lim_reissue", 32'(arvalid), 32'd1);
        check_eq("lim_reissue_addr", araddr, 32'h8);
        check_eq("lim_head_after_pop", pc_addr, 32'h4);

        // Redirect while request for 8 is pending
        do_reset(1'b1);
        cyc();
        rvalid = 1'b1;
        cyc();
        check_eq("pend_araddr8", araddr, 32'h8);
        arready = 1'b0;
        cyc();
        rvalid      = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h100;
        cyc();
        redir_valid = 1'b0;
        check_eq("pend_held_addr", araddr, 32'h8);
        check_eq("pend_held_valid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        cyc();
        check_eq("pend_next_araddr", araddr, 32'h100);
        check_eq("pend_head8", pc_addr, 32'h8);
        check_eq("pend_head8_stale", 32'(pc_stale), 32'd1);
        rvalid = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid  = 1'b0;
        check_eq("pend_head100", pc_addr, 32'h100);
        check_eq("pend_head100_stale", 32'(pc_stale), 32'd0);
        check_eq("pend_head100_ret", pc_ret_addr, 32'h104);

        // Redirect in the same cycle as arh of address 4
        do_reset(1'b1);
        cyc();
        redir_valid = 1'b1;
        redir_addr  = 32'h40;
        rvalid      = 1'b1;
        cyc();
        redir_valid = 1'b0;
        check_eq("same_araddr", araddr, 32'h40);
        check_eq("same_head4", pc_addr, 32'h4);
        check_eq("same_head4_stale", 32'(pc_stale), 32'd1);
        cyc();
        arready = 1'b0;
        rvalid  = 1'b0;
        check_eq("same_head40", pc_addr, 32'h40);
        check_eq("same_head40_stale", 32'(pc_stale), 32'd0);

        // Misaligned redirect faults without touching pc/epoch
        do_reset(1'b0);
        redir_valid = 1'b1;
        redir_addr  = 32'h102;
        cyc();
        redir_valid = 1'b0;
        check_eq("mis_fault", 32'(fault), 32'd1);
        check_eq("mis_fault_addr", fault_addr, 32'h102);
        check_eq("mis_pending_addr", araddr, 32'h0);
        check_eq("mis_pending_valid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        cyc();
        check_eq("mis_no_issue", 32'(arvalid), 32'd0);
        check_eq("mis_head", pc_addr, 32'h0);
        check_eq("mis_head_not_stale", 32'(pc_stale), 32'd0);

        // Error on a stale beat is ignored
        do_reset(1'b1);
        cyc();
        arready     = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h200;
        cyc();
        redir_valid = 1'b0;
        check_eq("stale_err_head_stale", 32'(pc_stale), 32'd1);
        rvalid = 1'b1;
        rresp  = 2'b10;
        cyc();
        rvalid = 1'b0;
        rresp  = 2'b00;
        check_eq("stale_err_no_fault", 32'(fault), 32'd0);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        check_eq("stale_err_next_addr", araddr, 32'h200);
        check_eq("stale_err_arvalid", 32'(arvalid), 32'd1);

        // Address wrap at the top of the address space
        do_reset(1'b0);
        redir_valid = 1'b1;
        redir_addr  = 32'hFFFF_FFFC;
        cyc();
        redir_valid = 1'b0;
        arready     = 1'b1;
        cyc();
        check_eq("wrap_araddr", araddr, 32'hFFFF_FFFC);
        rvalid = 1'b1;
        cyc();
        rvalid  = 1'b0;
        arready = 1'b0;
        check_eq("wrap_head", pc_addr, 32'hFFFF_FFFC);
        check_eq("wrap_ret", pc_ret_addr, 32'h0);
        check_eq("wrap_next_araddr", araddr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
